bht_update_sched: RTL and testbench
===================================

Name: bht_update_sched

Overview:
- Sits between the two EX pipes and the local BHT correction port. That port accepts only one update per cycle.
- Collects up to two resolved conditional-branch outcomes per cycle, buffers them in order in a small FIFO, and issues exactly one update per cycle.
- Honours a stall from the frontend, for example while the BHT is being re-indexed, and reports overflow drops.

Parameters:
- DEPTH, 4, FIFO entries. Power of two, ≥2.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex1_branch_type_i  in  2  EX pipe 1 branch type (00 no, 01 branch, 10 ret, 11 j).
- ex1_inst_addr_i  in  32  EX pipe 1 branch PC.
- ex1_branch_success_i  in  1  EX pipe 1 taken.
- ex2_branch_type_i  in  2  EX pipe 2 branch type. Pipe 2 is younger than pipe 1.
- ex2_inst_addr_i  in  32  EX pipe 2 branch PC.
- ex2_branch_success_i  in  1  EX pipe 2 taken.
- stall_i  in  1  inhibit issuing to the BHT this cycle.
- upd_ready_o  out  1  room for two pushes this cycle.
- bht_branch_type_o  out  2  to BHT ex_branch_type_i. 01 = update, 00 = idle.
- bht_inst_addr_o  out  32  to BHT ex_inst_addr_i.
- bht_branch_success_o  out  1  to BHT ex_branch_success_i.
- pending_o  out  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_o  out  1  one-cycle pulse: at least one push was dropped last edge.
- drop_cnt_o  out  CNT_W  saturating count of dropped pushes.

Behaviour:
- Reset (rst=0, asynchronous) clears the following:
  - count=0 and read/write pointers=0.
  - bht_branch_type_o=00, bht_inst_addr_o=0, bht_branch_success_o=0.
  - drop_o=0, drop_cnt_o=0.
  - upd_ready_o=1 follows from count=0.
- Reset asserted mid-operation discards all queued entries. No partial update is issued.
- Push qualification: a pipe pushes only when its type==01. Types 10, 11 and 00 are ignored, since returns and jumps carry no direction history.
- All outputs toward the BHT are registered. Each edge loads the output register as follows:
  - stall_i=1: type=00. Address and success hold their previous values. No pop.
  - stall_i=0, count>0: output register loads the FIFO head with type=01, and the head is popped.
  - stall_i=0, count=0, ex1 pushes: bypass. ex1 goes directly to the output register (latency 1 cycle). ex2, if pushing, is enqueued.
  - stall_i=0, count=0, only ex2 pushes: ex2 is bypassed to the output.
  - Otherwise: type=00.
- Ordering:
  - Updates reach the BHT strictly in age order: FIFO entries first, then ex1, then ex2.
  - A bypass never overtakes a queued entry.
- Capacity:
  - space = DEPTH − count, using count before this edge's pop.
  - Pushes are accepted in order ex1 then ex2 while space remains. A bypassed push does not consume space.
  - Excess pushes are dropped. On any drop, drop_o=1 for exactly the next cycle, and drop_cnt_o adds the number dropped (1 or 2), saturating at all-ones.
- Occupancy: count_next = count + accepted_enqueues − pop. Simultaneous push and pop in one edge is legal.
- Pointers wrap modulo DEPTH. Full is count==DEPTH; empty is count==0.
- upd_ready_o = (DEPTH − count) ≥ 2. It is combinational from the count register, so it is conservative and ignores this cycle's pop. Producers are expected to hold branches in EX while it is low. Drops are a safety net only.
- pending_o = count register.
- Only the FIFO head and the output register are observable. No same-address coalescing is performed.

Decomposition:
- Shared package (bp_pkg):
  - Branch-type constants: TYPE_NO=00, TYPE_BRANCH=01, TYPE_RET=10, TYPE_J=11.
  - 2-bit counter state constants SNT/WNT/WT/ST, shared with the BHT.
  - The update-entry struct {addr[31:0], success}.
- One sub-module, bht_upd_fifo: parameterised circular buffer with dual push, single pop, and count output.
- Arbitration, bypass, drop accounting and the output register live in bht_update_sched.

Test Plan:
- Reset then idle: after rst released, no pushes → bht_branch_type_o=00, upd_ready_o=1, pending_o=0, drop_cnt_o=0.
- Single bypass: count=0, ex1 = {01, 0x0000_1040, taken} at cycle t → cycle t+1 shows bht outputs {01, 0x0000_1040, 1}, pending_o=0.
- Dual push ordering: ex1 = {01, 0x100, 1} and ex2 = {01, 0x104, 0} in the same cycle →
  - next cycle: {01, 0x100, 1}, pending_o=1.
  - following cycle: {01, 0x104, 0}, pending_o=0.
- Type filtering: ex1 type=10 at 0x200, ex2 type=11 at 0x204 → no update issued, pending_o stays 0.
- Stall and overflow (DEPTH=4):
  - Hold stall_i=1 and push two branches per cycle for 3 cycles.
  - After cycle 2: pending_o=4 and upd_ready_o=0.
  - Cycle 3: both pushes dropped, so drop_o pulses once and drop_cnt_o=2.
  - Release stall: four updates issue back-to-back in push order, then type=00.
- Async reset mid-drain: with pending_o=3, pull rst low between edges → outputs and pending_o go to 0 immediately. After release, no stale update appears.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: branch-type encodings, 2-bit counter
// states used by the BHT, and the update entry carried through the scheduler.
package bp_pkg;

    localparam logic [1:0] TYPE_NO     = 2'b00;
    localparam logic [1:0] TYPE_BRANCH = 2'b01;
    localparam logic [1:0] TYPE_RET    = 2'b10;
    localparam logic [1:0] TYPE_J      = 2'b11;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef struct packed {
        logic [31:0] addr;
        logic        success;
    } upd_entry_t;

endpackage

// File: rtl/bht_upd_fifo.sv
// Circular buffer of pending BHT updates: up to two pushes and one pop per
// edge. Pushes are compacted by the caller (push_b implies push_a), and the
// caller guarantees it never pushes more than the free space.
module bht_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_a,
    input  upd_entry_t               data_a,
    input  logic                     push_b,
    input  upd_entry_t               data_b,
    input  logic                     pop,
    output upd_entry_t               head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    upd_entry_t     mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  n_push;

    assign n_push = CW'(push_a) + CW'(push_b);
    assign head   = mem[rd_ptr];

    // Storage writes; second push lands in the slot after the first.
    // NOTE: the data array has no reset -- only pointers and count define
    // validity, so stale contents are never observed and no reset fan-out is needed.
    always_ff @(posedge clk) begin
        if (push_a) mem[wr_ptr] <= data_a;
        if (push_b) mem[wr_ptr + PW'(1)] <= data_b;
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two).
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_push);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count  <= count + n_push - CW'(pop);
        end
    end

endmodule

// File: rtl/bht_update_sched.sv
// Serialises up to two resolved conditional branches per cycle from the EX
// pipes into the single-update-per-cycle BHT correction port, in age order,
// with a same-cycle bypass when nothing is queued and drop accounting.
module bht_update_sched
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               ex1_branch_type_i,
    input  logic [31:0]              ex1_inst_addr_i,
    input  logic                     ex1_branch_success_i,
    input  logic [1:0]               ex2_branch_type_i,
    input  logic [31:0]              ex2_inst_addr_i,
    input  logic                     ex2_branch_success_i,
    input  logic                     stall_i,
    output logic                     upd_ready_o,
    output logic [1:0]               bht_branch_type_o,
    output logic [31:0]              bht_inst_addr_o,
    output logic                     bht_branch_success_o,
    output logic [$clog2(DEPTH):0]   pending_o,
    output logic                     drop_o,
    output logic [CNT_W-1:0]         drop_cnt_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    upd_entry_t    ex1_entry, ex2_entry, head;
    upd_entry_t    data_a;
    logic [CW-1:0] count, space;
    logic          ex1_push, ex2_push;
    logic          bypass_ex1, bypass_ex2, pop;
    logic          want1, want2, acc1, acc2;
    logic          push_a, push_b;
    logic [1:0]    n_drop;
    logic [CNT_W:0] drop_sum;

    assign ex1_entry = '{addr: ex1_inst_addr_i, success: ex1_branch_success_i};
    assign ex2_entry = '{addr: ex2_inst_addr_i, success: ex2_branch_success_i};

    // Returns and jumps carry no direction history; only conditional branches update.
    assign ex1_push = (ex1_branch_type_i == TYPE_BRANCH);
    assign ex2_push = (ex2_branch_type_i == TYPE_BRANCH);

    // Space is taken before this edge's pop, so the ready flag is conservative.
    assign space       = CW'(DEPTH) - count;
    assign upd_ready_o = (space >= CW'(2));
    assign pending_o   = count;

    // Arbitration: pop vs bypass, then in-order acceptance of remaining pushes.
    // NOTE: every signal gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        bypass_ex1 = 1'b0;
        bypass_ex2 = 1'b0;
        pop        = 1'b0;
        if (!stall_i) begin
            if (count != '0) begin
                pop = 1'b1;
            end else if (ex1_push) begin
                bypass_ex1 = 1'b1;
            end else if (ex2_push) begin
                bypass_ex2 = 1'b1;
            end
        end
        want1  = ex1_push && !bypass_ex1;
        want2  = ex2_push && !bypass_ex2;
        acc1   = want1 && (space != '0);
        acc2   = want2 && (space > CW'(acc1));
        // Compact accepted pushes so the FIFO always fills slot a first.
        push_a = acc1 || acc2;
        push_b = acc1 && acc2;
        data_a = acc1 ? ex1_entry : ex2_entry;
        n_drop = 2'(want1 && !acc1) + 2'(want2 && !acc2);
    end

    bht_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_a (push_a),
        .data_a (data_a),
        .push_b (push_b),
        .data_b (ex2_entry),
        .pop    (pop),
        .head   (head),
        .count  (count)
    );

    assign drop_sum = {1'b0, drop_cnt_o} + (CNT_W + 1)'(n_drop);

    // Registered BHT port: queued head first, then bypass, else idle; stall holds payload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bht_branch_type_o    <= TYPE_NO;
            bht_inst_addr_o      <= '0;
            bht_branch_success_o <= 1'b0;
        end else if (stall_i) begin
            bht_branch_type_o    <= TYPE_NO;
        end else if (pop) begin
            bht_branch_type_o    <= TYPE_BRANCH;
            bht_inst_addr_o      <= head.addr;
            bht_branch_success_o <= head.success;
        end else if (bypass_ex1) begin
            bht_branch_type_o    <= TYPE_BRANCH;
            bht_inst_addr_o      <= ex1_entry.addr;
            bht_branch_success_o <= ex1_entry.success;
        end else if (bypass_ex2) begin
            bht_branch_type_o    <= TYPE_BRANCH;
            bht_inst_addr_o      <= ex2_entry.addr;
            bht_branch_success_o <= ex2_entry.success;
        end else begin
            bht_branch_type_o    <= TYPE_NO;
        end
    end

    // Drop pulse for one cycle and saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_o     <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            drop_o     <= (n_drop != 2'd0);
            drop_cnt_o <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_bht_update_sched.sv
// Directed bench for bht_update_sched. Expected updates are queued when
// stimulus is applied; a monitor pops and compares each issued BHT update.
module tb_bht_update_sched;
    import bp_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic [1:0]        ex1_branch_type_i;
    logic [31:0]       ex1_inst_addr_i;
    logic              ex1_branch_success_i;
    logic [1:0]        ex2_branch_type_i;
    logic [31:0]       ex2_inst_addr_i;
    logic              ex2_branch_success_i;
    logic              stall_i;
    logic              upd_ready_o;
    logic [1:0]        bht_branch_type_o;
    logic [31:0]       bht_inst_addr_o;
    logic              bht_branch_success_o;
    logic [CW-1:0]     pending_o;
    logic              drop_o;
    logic [CNT_W-1:0]  drop_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    upd_entry_t sb[$];

    bht_update_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ex1_branch_type_i    (ex1_branch_type_i),
        .ex1_inst_addr_i      (ex1_inst_addr_i),
        .ex1_branch_success_i (ex1_branch_success_i),
        .ex2_branch_type_i    (ex2_branch_type_i),
        .ex2_inst_addr_i      (ex2_inst_addr_i),
        .ex2_branch_success_i (ex2_branch_success_i),
        .stall_i              (stall_i),
        .upd_ready_o          (upd_ready_o),
        .bht_branch_type_o    (bht_branch_type_o),
        .bht_inst_addr_o      (bht_inst_addr_o),
        .bht_branch_success_o (bht_branch_success_o),
        .pending_o            (pending_o),
        .drop_o               (drop_o),
        .drop_cnt_o           (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_upd(input logic [31:0] addr, input logic success);
        upd_entry_t e;
        e.addr    = addr;
        e.success = success;
        sb.push_back(e);
    endtask

    // Apply one cycle of stimulus; returns at the following negedge.
    task automatic cycle(input logic [1:0] t1, input logic [31:0] a1, input logic s1,
                         input logic [1:0] t2, input logic [31:0] a2, input logic s2,
                         input logic st);
        ex1_branch_type_i    = t1;
        ex1_inst_addr_i      = a1;
        ex1_branch_success_i = s1;
        ex2_branch_type_i    = t2;
        ex2_inst_addr_i      = a2;
        ex2_branch_success_i = s2;
        stall_i              = st;
        @(negedge clk);
    endtask

    task automatic idle(input logic st);
        cycle(TYPE_NO, 32'h0, 1'b0, TYPE_NO, 32'h0, 1'b0, st);
    endtask

    // Monitor: every issued update must match the oldest expected one.
    always @(negedge clk) begin : monitor
        upd_entry_t e;
        if (rst && bht_branch_type_o == TYPE_BRANCH) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_update: got addr 0x%0h, expected no update", bht_inst_addr_o);
            end else begin
                e = sb.pop_front();
                check("upd_addr", 64'(bht_inst_addr_o), 64'(e.addr));
                check("upd_success", 64'(bht_branch_success_o), 64'(e.success));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b0;
        ex1_branch_type_i = TYPE_NO; ex1_inst_addr_i = '0; ex1_branch_success_i = 1'b0;
        ex2_branch_type_i = TYPE_NO; ex2_inst_addr_i = '0; ex2_branch_success_i = 1'b0;
        stall_i = 1'b0;
        #2;
        check("rst_type", 64'(bht_branch_type_o), 64'(TYPE_NO));
        check("rst_addr", 64'(bht_inst_addr_o), 64'h0);
        check("rst_ready", 64'(upd_ready_o), 64'h1);
        check("rst_pending", 64'(pending_o), 64'h0);
        check("rst_drop", 64'(drop_o), 64'h0);
        check("rst_drop_cnt", 64'(drop_cnt_o), 64'h0);
        @(negedge clk);
        rst = 1'b1;

        // Idle after reset
        idle(1'b0);
        check("idle_type", 64'(bht_branch_type_o), 64'(TYPE_NO));
        check("idle_ready", 64'(upd_ready_o), 64'h1);
        check("idle_pending", 64'(pending_o), 64'h0);

        // Single bypass of ex1
        expect_upd(32'h0000_1040, 1'b1);
        cycle(TYPE_BRANCH, 32'h0000_1040, 1'b1, TYPE_NO, 32'h0, 1'b0, 1'b0);
        check("bypass_type", 64'(bht_branch_type_o), 64'(TYPE_BRANCH));
        check("bypass_pending", 64'(pending_o), 64'h0);
        idle(1'b0);
        check("bypass_after_type", 64'(bht_branch_type_o), 64'(TYPE_NO));

        // Dual push: ex1 bypassed, ex2 queued then issued
        expect_upd(32'h100, 1'b1);
        expect_upd(32'h104, 1'b0);
        cycle(TYPE_BRANCH, 32'h100, 1'b1, TYPE_BRANCH, 32'h104, 1'b0, 1'b0);
        check("dual1_type", 64'(bht_branch_type_o), 64'(TYPE_BRANCH));
        check("dual1_pending", 64'(pending_o), 64'h1);
        idle(1'b0);
        check("dual2_type", 64'(bht_branch_type_o), 64'(TYPE_BRANCH));
        check("dual2_pending", 64'(pending_o), 64'h0);
        idle(1'b0);
        check("dual3_type", 64'(bht_branch_type_o), 64'(TYPE_NO));

        // Type filtering: ret and jump are ignored
        cycle(TYPE_RET, 32'h200, 1'b1, TYPE_J, 32'h204, 1'b1, 1'b0);
        check("filter_type", 64'(bht_branch_type_o), 64'(TYPE_NO));
        check("filter_pending", 64'(pending_o), 64'h0);
        idle(1'b0);
        check("filter2_pending", 64'(pending_o), 64'h0);

        // Only ex2 pushes while empty: bypassed
        expect_upd(32'h300, 1'b1);
        cycle(TYPE_NO, 32'h0, 1'b0, TYPE_BRANCH, 32'h300, 1'b1, 1'b0);
        check("ex2byp_type", 64'(bht_branch_type_o), 64'(TYPE_BRANCH));
        check("ex2byp_pending", 64'(pending_o), 64'h0);
        idle(1'b0);

        // Stall and overflow
        expect_upd(32'h500, 1'b1);
        expect_upd(32'h504, 1'b0);
        cycle(TYPE_BRANCH, 32'h500, 1'b1, TYPE_BRANCH, 32'h504, 1'b0, 1'b1);
        check("stall1_type", 64'(bht_branch_type_o), 64'(TYPE_NO));
        check("stall1_addr_hold", 64'(bht_inst_addr_o), 64'h300);
        check("stall1_succ_hold", 64'(bht_branch_success_o), 64'h1);
        check("stall1_pending", 64'(pending_o), 64'h2);
        check("stall1_ready", 64'(upd_ready_o), 64'h1);
        expect_upd(32'h508, 1'b0);
        expect_upd(32'h50c, 1'b1);
        cycle(TYPE_BRANCH, 32'h508, 1'b0, TYPE_BRANCH, 32'h50c, 1'b1, 1'b1);
        check("stall2_pending", 64'(pending_o), 64'h4);
        check("stall2_ready", 64'(upd_ready_o), 64'h0);
        check("stall2_drop", 64'(drop_o), 64'h0);
        cycle(TYPE_BRANCH, 32'h510, 1'b1, TYPE_BRANCH, 32'h514, 1'b1, 1'b1);
        check("stall3_pending", 64'(pending_o), 64'h4);
        check("stall3_drop", 64'(drop_o), 64'h1);
        check("stall3_drop_cnt", 64'(drop_cnt_o), 64'h2);
        check("stall3_type", 64'(bht_branch_type_o), 64'(TYPE_NO));
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            check("drain_type", 64'(bht_branch_type_o), 64'(TYPE_BRANCH));
            check("drain_pending", 64'(pending_o), 64'(3 - i));
            if (i == 0) check("drain_drop_pulse_end", 64'(drop_o), 64'h0);
        end
        idle(1'b0);
        check("drain_done_type", 64'(bht_branch_type_o), 64'(TYPE_NO));
        check("drain_done_ready", 64'(upd_ready_o), 64'h1);

        // Partial overflow without stall: pop plus one accept, one drop
        expect_upd(32'h400, 1'b1);
        expect_upd(32'h404, 1'b0);
        cycle(TYPE_BRANCH, 32'h400, 1'b1, TYPE_BRANCH, 32'h404, 1'b0, 1'b1);
        expect_upd(32'h408, 1'b1);
        cycle(TYPE_BRANCH, 32'h408, 1'b1, TYPE_NO, 32'h0, 1'b0, 1'b1);
        check("part_pending3", 64'(pending_o), 64'h3);
        check("part_ready", 64'(upd_ready_o), 64'h0);
        expect_upd(32'h40c, 1'b0);
        cycle(TYPE_BRANCH, 32'h40c, 1'b0, TYPE_BRANCH, 32'h410, 1'b1, 1'b0);
        check("part_type", 64'(bht_branch_type_o), 64'(TYPE_BRANCH));
        check("part_pending", 64'(pending_o), 64'h3);
        check("part_drop", 64'(drop_o), 64'h1);
        check("part_drop_cnt", 64'(drop_cnt_o), 64'h3);

        // Async reset mid-drain with three entries queued
        ex1_branch_type_i = TYPE_NO;
        ex2_branch_type_i = TYPE_NO;
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        check("arst_type", 64'(bht_branch_type_o), 64'(TYPE_NO));
        check("arst_addr", 64'(bht_inst_addr_o), 64'h0);
        check("arst_succ", 64'(bht_branch_success_o), 64'h0);
        check("arst_pending", 64'(pending_o), 64'h0);
        check("arst_drop", 64'(drop_o), 64'h0);
        check("arst_drop_cnt", 64'(drop_cnt_o), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            check("post_rst_type", 64'(bht_branch_type_o), 64'(TYPE_NO));
            check("post_rst_pending", 64'(pending_o), 64'h0);
        end

        check("scoreboard_empty", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
